prio_arbiter: RTL

PRIO_ARBITER -- requirements
Module: prio_arbiter

---
 rtl/prio_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/prio_arbiter.sv
// rtl/prio_arbiter.sv - 8-way resource arbiter, fixed or round-robin priority with hold timeout
//
// Purpose:
//   Grants a shared resource to one of eight requesters. After a grant the
//   block stays BUSY until the grantee signals done, drops its request, or
//   holds the resource for HOLD_MAX cycles. It then spends one IDLE cycle
//   before it arbitrates again.
//
// Parameters:
//   RR_EN     1 = round-robin starting at ptr, 0 = fixed priority (highest index wins)
//   HOLD_MAX  maximum grant length in cycles; 0 disables the forced release
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   req[7:0]     request lines, bit i = requester i
//   done         grantee releases the resource (sampled only in BUSY)
//   grant[7:0]   registered one-hot grant
//   grant_id     registered binary index of the grantee
//   grant_valid  high exactly when grant is nonzero
//   timeout      one-cycle pulse coincident with a forced release

module prio_arbiter #(
    parameter int RR_EN    = 1,
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    localparam int HCW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HCW-1:0] HOLD_LAST = (HOLD_MAX > 0) ? HCW'(HOLD_MAX - 1) : '0;
    localparam logic [HCW-1:0] HOLD_SAT  = '1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       grant_q, grant_d;
    logic [2:0]       grant_id_q, grant_id_d;
    logic             grant_valid_q, grant_valid_d;
    logic             timeout_q, timeout_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;

    logic [2:0]       winner_id;
    logic             winner_found;
    logic [2:0]       scan_idx;
    logic             hold_hit;
    logic             req_drop;

    // Winner selection. Round-robin scans upward from ptr with 3-bit wrap;
    // fixed priority lets the last (highest) set bit overwrite earlier ones.
    always_comb begin
        winner_id    = 3'd0;
        winner_found = 1'b0;
        scan_idx     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (RR_EN != 0) begin
                scan_idx = ptr_q + 3'(i);
                if (!winner_found && req[scan_idx]) begin
                    winner_id    = scan_idx;
                    winner_found = 1'b1;
                end
            end else if (req[i]) begin
                winner_id    = 3'(i);
                winner_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        hold_hit      = 1'b0;
        req_drop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    state_d       = BUSY;
                    grant_d       = 8'd1 << winner_id;
                    grant_id_d    = winner_id;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = '0;
                end
            end
            BUSY: begin
                hold_hit = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);
                req_drop = !req[grant_id_q];
                if (done || req_drop || hold_hit) begin
                    state_d       = IDLE;
                    grant_d       = 8'd0;
                    grant_id_d    = 3'd0;
                    grant_valid_d = 1'b0;
                    ptr_d         = grant_id_q + 3'd1;
                    // A forced release is only reported when nothing else ended the grant.
                    timeout_d     = hold_hit && !done && !req_drop;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= 8'd0;
            grant_id_q    <= 3'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            ptr_q         <= 3'd0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule
